// File: rtl/bus_mux_arbiter.sv
// Round-robin arbiter for one shared datapath bus.
// Drives one-hot grants and the mux-tree select. One dead cycle (GAP) separates
// consecutive owners so the mux never switches under an active driver.
// Optional feature: define ARB_TIMEOUT_EN to add a hold counter that force-revokes
// a grant held for MAX_HOLD cycles while another requester is waiting.
module bus_mux_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_busy,
  output logic             o_timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic             revoke;

  // Winner search: first active request at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [SEL_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      // SEL_W-bit addition wraps N_REQ-1 -> 0 since N_REQ is a power of two.
      cand = rr_ptr_q + SEL_W'(i);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
  logic [N_REQ-1:0] others;

  // Forced revoke: owner has held MAX_HOLD cycles and someone else is waiting.
  always_comb begin
    others = i_req & ~(N_REQ'(1) << sel_q);
    revoke = (state_q == StGrant) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) &&
             i_req[sel_q] && (|others);
  end

  // Hold counter clears on GRANT entry and saturates at MAX_HOLD.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    timeout_d  = revoke;
    if (state_d == StGrant && state_q != StGrant) begin
      hold_cnt_d = '0;
    end else if (state_q == StGrant && hold_cnt_q != CNT_W'(MAX_HOLD)) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic [CNT_W-1:0] unused_hold_cfg;
  assign unused_hold_cfg = CNT_W'(MAX_HOLD);
  assign revoke          = 1'b0;
  assign o_timeout       = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE/GAP, hold in GRANT until release or revoke.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle, StGap: begin
        if (win_found) begin
          state_d = StGrant;
          gnt_d   = N_REQ'(1) << win_idx;
          sel_d   = win_idx;
        end else begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      StGrant: begin
        if (!i_req[sel_q] || revoke) begin
          state_d  = StGap;
          gnt_d    = '0;
          rr_ptr_d = sel_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign o_gnt  = gnt_q;
  assign o_sel  = sel_q;
  assign o_busy = (state_q == StGrant);

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Self-checking bench for bus_mux_arbiter: vector table, corner sequences and
// randomized traffic against a behavioural round-robin model.
module tb_bus_mux_arbiter;

  localparam int N = 4;
  localparam int MaxHold = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       tmo;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: owner index (-1 none), round-robin pointer, last owner,
  // grant cycles so far, timeout pulse.
  int m_owner, m_ptr, m_last, m_cycles;
  bit m_to;

  bus_mux_arbiter #(.N_REQ(4), .SEL_W(2), .MAX_HOLD(16), .CNT_W(5)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .o_gnt    (gnt),
    .o_sel    (sel),
    .o_busy   (busy),
    .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_last = 0; m_cycles = 0; m_to = 1'b0;
  endtask

  // One clock edge of the reference behaviour, given the sampled requests.
  task automatic model_edge(input logic [3:0] r);
    bit rev;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      rev = TimeoutEn && (m_cycles == MaxHold) && r[m_owner] &&
            ((r & ~(4'b1 << m_owner)) != 4'b0);
      if (!r[m_owner] || rev) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_to    = rev;
      end else begin
        m_cycles++;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && r[(m_ptr + i) % N]) begin
          m_owner  = (m_ptr + i) % N;
          m_last   = m_owner;
          m_cycles = 1;
        end
      end
    end
  endtask

  task automatic model_cmp();
    chk("model_gnt", 32'(gnt), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
    chk("model_sel", 32'(sel), 32'(m_last));
    chk("model_busy", 32'(busy), 32'(m_owner >= 0));
    chk("model_timeout", 32'(tmo), 32'(m_to));
    chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  // Drive requests for one cycle, step the model at the edge, compare after it.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    model_cmp();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_timeout", 32'(tmo), 32'd0);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [3:0] r;

    // Hand-derived cycle table starting from reset (rr_ptr = 0).
    tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};  // single requester, 1-cycle latency
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};  // GAP, sel holds
    tbl[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};  // IDLE
    tbl[5]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};  // rr_ptr=3 beats lower index
    tbl[6]  = '{4'b0001, 4'b0000, 2'd3, 1'b0};  // GAP, rr_ptr wraps to 0
    tbl[7]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};  // arbitration in GAP
    tbl[8]  = '{4'b1001, 4'b0001, 2'd0, 1'b1};  // other requests ignored
    tbl[9]  = '{4'b1000, 4'b0000, 2'd0, 1'b0};  // handoff GAP
    tbl[10] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[11] = '{4'b0010, 4'b0000, 2'd3, 1'b0};
    tbl[12] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 2'd1, 1'b0};  // rr_ptr=2
    tbl[14] = '{4'b0001, 4'b0001, 2'd0, 1'b1};  // search 2,3,0
    tbl[15] = '{4'b0000, 4'b0000, 2'd0, 1'b0};  // requester gone before sampling
    tbl[16] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[17] = '{4'b0000, 4'b0000, 2'd1, 1'b0};  // release, rr_ptr=2
    tbl[18] = '{4'b0011, 4'b0001, 2'd0, 1'b1};  // re-raised req1 goes behind req0
    tbl[19] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[20] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].req);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    end

    // Asynchronous reset during a grant to req1 clears outputs before any edge.
    do_reset();
    step(4'b0010);
    step(4'b0010);
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_sel", 32'(sel), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(4'b1111);
    chk("post_rst_gnt", 32'(gnt), 32'h1);

    // Fairness: all requesting, each owner keeps the bus 3 cycles.
    do_reset();
    step(4'hF);
    for (int k = 0; k < 5; k++) begin
      chk("fair_owner", 32'(gnt), 32'(1 << (k % 4)));
      step(4'hF);
      step(4'hF);
      step(4'hF & ~(4'b1 << (k % 4)));
      chk("fair_dead_cycle", 32'(gnt), 32'd0);
      step(4'hF);
    end

    // Lone long holder never times out, with or without the timeout feature.
    do_reset();
    step(4'b0010);
    for (int c = 0; c < 40; c++) begin
      step(4'b0010);
      chk("lone_gnt", 32'(gnt), 32'h2);
      chk("lone_timeout", 32'(tmo), 32'd0);
    end

`ifdef ARB_TIMEOUT_EN
    // Forced revoke after 16 grant cycles when req2 waits.
    do_reset();
    step(4'b0010);
    step(4'b0010);
    step(4'b0110);
    for (int c = 4; c <= 16; c++) begin
      step(4'b0110);
      chk("hold_gnt", 32'(gnt), 32'h2);
    end
    step(4'b0110);
    chk("revoke_gnt", 32'(gnt), 32'd0);
    chk("revoke_timeout", 32'(tmo), 32'd1);
    step(4'b0110);
    chk("after_revoke_gnt", 32'(gnt), 32'h4);
    chk("after_revoke_timeout", 32'(tmo), 32'd0);
`endif

    // Randomized traffic: sticky request bits that occasionally flip.
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      step(r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
